// File: rtl/pinball_pkg.sv
// Shared pinball constants: screen geometry, fixed-point scaling, hit-edge bit
// positions and the ball motion state encoding.
package pinball_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int FIXED_SHIFT   = 6;

    localparam int EDGE_TOP    = 3;
    localparam int EDGE_BOTTOM = 2;
    localparam int EDGE_LEFT   = 1;
    localparam int EDGE_RIGHT  = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_VEL,
        S_POS
    } ball_state_t;

endpackage

// File: rtl/ball_velocity_calc.sv
// Per-frame velocity update: edge bounce, then gravity, then per-axis speed clamp.
// Purely combinational; the caller registers the result.
module ball_velocity_calc
    import pinball_pkg::*;
#(
    parameter int GRAVITY   = 8,
    parameter int MAX_SPEED = 1024
) (
    input  logic signed [31:0] vx_in,
    input  logic signed [31:0] vy_in,
    input  logic [3:0]         flags,
    output logic signed [31:0] vx_out,
    output logic signed [31:0] vy_out
);

    localparam logic signed [31:0] VMAX = 32'(MAX_SPEED);
    localparam logic signed [31:0] GRAV = 32'(GRAVITY);

    logic signed [31:0] vx_b;
    logic signed [31:0] vy_b;
    logic signed [31:0] vy_g;

    always_comb begin
        // A hit only reflects motion heading into that edge.
        vx_b = vx_in;
        if ((flags[EDGE_LEFT] && vx_in < 0) || (flags[EDGE_RIGHT] && vx_in > 0))
            vx_b = -vx_in;
        vy_b = vy_in;
        if ((flags[EDGE_TOP] && vy_in < 0) || (flags[EDGE_BOTTOM] && vy_in > 0))
            vy_b = -vy_in;
        vy_g = vy_b + GRAV;

        vx_out = vx_b;
        if (vx_b > VMAX)
            vx_out = VMAX;
        else if (vx_b < -VMAX)
            vx_out = -VMAX;

        vy_out = vy_g;
        if (vy_g > VMAX)
            vy_out = VMAX;
        else if (vy_g < -VMAX)
            vy_out = -VMAX;
    end

endmodule

// File: rtl/ball_motion.sv
// Ball position generator: integrates fixed-point velocity once per frame with
// bounces from hits collected during the previous frame; outputs are registered.
module ball_motion
    import pinball_pkg::*;
#(
    parameter int INITIAL_X     = 280,
    parameter int INITIAL_Y     = 400,
    parameter int INITIAL_VX    = -96,
    parameter int INITIAL_VY    = -640,
    parameter int GRAVITY       = 8,
    parameter int MAX_SPEED     = 1024,
    parameter int OBJECT_WIDTH  = 32,
    parameter int OBJECT_HEIGHT = 32,
    parameter int DRAIN_Y       = 448
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               launch,
    input  logic               collision,
    input  logic [3:0]         hitEdgeCode,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               moving,
    output logic               ballLost
);

    localparam logic signed [31:0] PARK_X    = 32'(INITIAL_X * (1 << FIXED_SHIFT));
    localparam logic signed [31:0] PARK_Y    = 32'(INITIAL_Y * (1 << FIXED_SHIFT));
    localparam logic signed [31:0] X_MAX_PIX = 32'(SCREEN_WIDTH - OBJECT_WIDTH);
    localparam logic signed [31:0] X_MAX_FIX = 32'((SCREEN_WIDTH - OBJECT_WIDTH) * (1 << FIXED_SHIFT));
    localparam logic signed [31:0] DRAIN_PIX = 32'(DRAIN_Y);

    if (OBJECT_WIDTH < 1 || OBJECT_HEIGHT < 1 || DRAIN_Y > SCREEN_HEIGHT) begin : g_bad_cfg
        $error("ball_motion: object size or drain line outside the screen");
    end

    ball_state_t        state_q, state_d;
    logic signed [31:0] posx_q, posx_d, posy_q, posy_d;
    logic signed [31:0] vx_q, vx_d, vy_q, vy_d;
    logic [3:0]         hit_q, hit_d, snap_q, snap_d;
    logic signed [10:0] tlx_d, tly_d;
    logic               moving_d, lost_d;

    logic signed [31:0] vx_new, vy_new;
    logic signed [31:0] sum_x, sum_y, pix_x, pix_y;
    logic signed [31:0] cx, cy, cvx, cvy;

    ball_velocity_calc #(
        .GRAVITY   (GRAVITY),
        .MAX_SPEED (MAX_SPEED)
    ) u_vel (
        .vx_in  (vx_q),
        .vy_in  (vy_q),
        .flags  (snap_q),
        .vx_out (vx_new),
        .vy_out (vy_new)
    );

    // Edge clamp on the integrated position; an outward velocity is reflected.
    always_comb begin
        sum_x = posx_q + vx_q;
        sum_y = posy_q + vy_q;
        pix_x = sum_x >>> FIXED_SHIFT;
        pix_y = sum_y >>> FIXED_SHIFT;
        cx  = sum_x;
        cy  = sum_y;
        cvx = vx_q;
        cvy = vy_q;
        if (pix_x < 0) begin
            cx = '0;
            if (vx_q < 0) cvx = -vx_q;
        end else if (pix_x > X_MAX_PIX) begin
            cx = X_MAX_FIX;
            if (vx_q > 0) cvx = -vx_q;
        end
        if (pix_y < 0) begin
            cy = '0;
            if (vy_q < 0) cvy = -vy_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        posx_d   = posx_q;
        posy_d   = posy_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        hit_d    = hit_q;
        snap_d   = snap_q;
        tlx_d    = topLeftX;
        tly_d    = topLeftY;
        moving_d = moving;
        lost_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    vx_d     = 32'(INITIAL_VX);
                    vy_d     = 32'(INITIAL_VY);
                    moving_d = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // A hit on the frame-start cycle lands in the new frame's flags.
                if (startOfFrame) begin
                    snap_d  = hit_q;
                    hit_d   = collision ? hitEdgeCode : 4'b0000;
                    state_d = S_VEL;
                end else if (collision) begin
                    hit_d = hit_q | hitEdgeCode;
                end
            end
            S_VEL: begin
                vx_d    = vx_new;
                vy_d    = vy_new;
                state_d = S_POS;
            end
            S_POS: begin
                if (pix_y >= DRAIN_PIX) begin
                    posx_d   = PARK_X;
                    posy_d   = PARK_Y;
                    vx_d     = '0;
                    vy_d     = '0;
                    hit_d    = '0;
                    snap_d   = '0;
                    tlx_d    = 11'(INITIAL_X);
                    tly_d    = 11'(INITIAL_Y);
                    moving_d = 1'b0;
                    lost_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    posx_d  = cx;
                    posy_d  = cy;
                    vx_d    = cvx;
                    vy_d    = cvy;
                    tlx_d   = cx[FIXED_SHIFT +: 11];
                    tly_d   = cy[FIXED_SHIFT +: 11];
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            posx_q   <= PARK_X;
            posy_q   <= PARK_Y;
            vx_q     <= '0;
            vy_q     <= '0;
            hit_q    <= '0;
            snap_q   <= '0;
            topLeftX <= 11'(INITIAL_X);
            topLeftY <= 11'(INITIAL_Y);
            moving   <= 1'b0;
            ballLost <= 1'b0;
        end else begin
            state_q  <= state_d;
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            hit_q    <= hit_d;
            snap_q   <= snap_d;
            topLeftX <= tlx_d;
            topLeftY <= tly_d;
            moving   <= moving_d;
            ballLost <= lost_d;
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: launch, bounces, deferred frame-start hits,
// drain/restart, reset mid-update, plus direct velocity clamp vectors.
module tb_ball_motion;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               launch = 1'b0;
    logic               collision = 1'b0;
    logic [3:0]         hitEdgeCode = 4'b0000;
    logic signed [10:0] topLeftX, topLeftY;
    logic               moving, ballLost;

    logic signed [31:0] vc_vx_in = '0, vc_vy_in = '0;
    logic [3:0]         vc_flags = '0;
    logic signed [31:0] vc_vx_out, vc_vy_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .launch       (launch),
        .collision    (collision),
        .hitEdgeCode  (hitEdgeCode),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .moving       (moving),
        .ballLost     (ballLost)
    );

    ball_velocity_calc #(.GRAVITY(8), .MAX_SPEED(1024)) u_vc (
        .vx_in  (vc_vx_in),
        .vy_in  (vc_vy_in),
        .flags  (vc_flags),
        .vx_out (vc_vx_out),
        .vy_out (vc_vy_out)
    );

    task automatic check(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check({tag, "_x"}, int'(topLeftX), x);
        check({tag, "_y"}, int'(topLeftY), y);
    endtask

    task automatic hit(input logic [3:0] code);
        collision = 1'b1;
        hitEdgeCode = code;
        tick();
        collision = 1'b0;
        hitEdgeCode = 4'b0000;
        tick();
    endtask

    // Frame-start pulse with optional same-cycle hit; launch can be held during S_POS.
    task automatic run_frame(input logic [3:0] sof_hit, input logic launch_in_pos);
        startOfFrame = 1'b1;
        collision = (sof_hit != 4'b0000);
        hitEdgeCode = sof_hit;
        tick();
        startOfFrame = 1'b0;
        collision = 1'b0;
        hitEdgeCode = 4'b0000;
        tick();
        launch = launch_in_pos;
        tick();
        launch = 1'b0;
    endtask

    task automatic do_launch();
        launch = 1'b1;
        tick();
        launch = 1'b0;
    endtask

    initial begin
        int frames;
        logic lost_seen;

        // Velocity clamp vectors
        vc_vx_in = 0; vc_vy_in = 1020; vc_flags = 4'b0000; #1;
        check("vc_grav_clamp", vc_vy_out, 1024);
        vc_vy_in = -1030; vc_flags = 4'b1000; #1;
        check("vc_top_bounce_clamp", vc_vy_out, 1024);
        vc_vy_in = -1040; vc_flags = 4'b0100; #1;
        check("vc_bottom_ignored_clamp", vc_vy_out, -1024);
        vc_vx_in = -2000; vc_vy_in = 0; vc_flags = 4'b0010; #1;
        check("vc_left_bounce_clamp", vc_vx_out, 1024);
        vc_vx_in = 96; vc_flags = 4'b0010; #1;
        check("vc_left_ignored", vc_vx_out, 96);

        // Reset state
        tick(); tick();
        check_pos("reset", 280, 400);
        check("reset_moving", int'(moving), 0);
        check("reset_lost", int'(ballLost), 0);
        resetN = 1'b1;
        tick();

        run_frame(4'b0000, 1'b0);
        tick();
        check_pos("idle_sof", 280, 400);
        check("idle_moving", int'(moving), 0);

        // Launch and first frame latency
        do_launch();
        check("launch_moving", int'(moving), 1);
        tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("lat_t1_x", int'(topLeftX), 280);
        tick();
        check("lat_t2_x", int'(topLeftX), 280);
        tick();
        check_pos("frame1", 278, 390);
        tick();

        // Left hit on the frame-start cycle is deferred one frame
        run_frame(4'b0010, 1'b0);
        check_pos("sof_hit_deferred", 277, 380);
        tick(); tick();
        run_frame(4'b0000, 1'b0);
        check_pos("sof_hit_applied", 278, 370);
        tick();

        // Left hit with vX already positive is ignored
        hit(4'b0010);
        run_frame(4'b0000, 1'b0);
        check_pos("left_ignored", 280, 361);
        tick();

        // Right hit with vX positive reflects
        hit(4'b0001);
        run_frame(4'b0000, 1'b0);
        check_pos("right_bounce", 278, 351);
        check("run_moving", int'(moving), 1);

        // Drain from a fresh launch; launch held in S_POS must be ignored
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        do_launch();
        tick();
        frames = 0;
        lost_seen = 1'b0;
        for (int i = 0; i < 200 && !lost_seen; i++) begin
            run_frame(4'b0000, 1'b1);
            frames++;
            if (ballLost) lost_seen = 1'b1;
            else tick();
        end
        check("drain_frames", frames, 164);
        check("drain_lost", int'(ballLost), 1);
        check("drain_moving", int'(moving), 0);
        check_pos("drain_park", 280, 400);
        tick();
        check("lost_pulse_end", int'(ballLost), 0);
        check("launch_in_pos_ignored", int'(moving), 0);

        // Restart
        do_launch();
        check("restart_moving", int'(moving), 1);
        tick();
        run_frame(4'b0000, 1'b0);
        check_pos("restart_frame1", 278, 390);
        tick();

        // Reset asserted while in S_POS
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        resetN = 1'b0;
        #1;
        check_pos("rst_pos_async", 280, 400);
        check("rst_pos_moving", int'(moving), 0);
        tick();
        check_pos("rst_pos_held", 280, 400);
        check("rst_pos_lost", int'(ballLost), 0);
        resetN = 1'b1;
        tick();
        run_frame(4'b0000, 1'b0);
        tick();
        check_pos("rst_then_idle", 280, 400);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
